alu_wb: RTL

Writeback stage directly downstream of the 8-bit ALU. Per instruction it captures the ALU result byte and candidate C/DC/Z flags and commits them to the W register, the STATUS register, or the external file register port. It also implements skip-on-zero squashing of the following instruction and back-pressure toward the issue stage. `status[0]` is fed back as the ALU carry input.

---
 rtl/alu_wb.sv | 106 ++++++++++
 1 files changed

// File: rtl/alu_wb.sv
// Writeback stage behind the 8-bit ALU: commits results to W, STATUS or the
// external file port, squashes the instruction after a taken skip, and stalls issue.
module alu_wb (
    input  logic       clk,
    input  logic       rst,
    input  logic       wb_valid,
    output logic       wb_ready,
    input  logic [7:0] alu_out,
    input  logic       c_new,
    input  logic       dc_new,
    input  logic       z_new,
    input  logic       upd_c,
    input  logic       upd_dc,
    input  logic       upd_z,
    input  logic       dest_f,
    input  logic [4:0] f_addr,
    input  logic       skip_z,
    output logic [7:0] w_reg,
    output logic [7:0] status,
    output logic       f_we,
    output logic [4:0] f_waddr,
    output logic [7:0] f_wdata,
    input  logic       f_ack,
    output logic       skip_out
);

    localparam logic [4:0] STATUS_ADDR = 5'h03;
    localparam logic [7:0] STATUS_RST  = 8'h18;

    typedef enum logic {RUN, SQUASH}    skip_state_t;
    typedef enum logic {F_IDLE, F_PEND} file_state_t;

    skip_state_t skip_q, skip_d;
    file_state_t fst_q, fst_d;
    logic [7:0]  w_q, w_d;
    logic [7:0]  st_q, st_d;
    logic [4:0]  fa_q, fa_d;
    logic [7:0]  fd_q, fd_d;
    logic        accept;
    logic        commit;

    assign wb_ready = (fst_q == F_IDLE) | f_ack;
    assign accept   = wb_valid & wb_ready;
    assign commit   = accept & (skip_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_q <= RUN;
            fst_q  <= F_IDLE;
            w_q    <= 8'h00;
            st_q   <= STATUS_RST;
            fa_q   <= 5'h00;
            fd_q   <= 8'h00;
        end else begin
            skip_q <= skip_d;
            fst_q  <= fst_d;
            w_q    <= w_d;
            st_q   <= st_d;
            fa_q   <= fa_d;
            fd_q   <= fd_d;
        end
    end

    always_comb begin
        skip_d = skip_q;
        fst_d  = fst_q;
        w_d    = w_q;
        st_d   = st_q;
        fa_d   = fa_q;
        fd_d   = fd_q;

        if (accept) begin
            case (skip_q)
                RUN:     if (skip_z && z_new) skip_d = SQUASH;
                SQUASH:  skip_d = RUN;
                default: skip_d = RUN;
            endcase
        end

        if (fst_q == F_PEND && f_ack) fst_d = F_IDLE;

        if (commit) begin
            if (!dest_f) begin
                w_d = alu_out;
            end else if (f_addr == STATUS_ADDR) begin
                st_d = {alu_out[7:5], 2'b11, alu_out[2:0]};
            end else begin
                // A new write loaded on the ack edge keeps f_we high with no bubble
                fst_d = F_PEND;
                fa_d  = f_addr;
                fd_d  = alu_out;
            end
            if (upd_c)  st_d[0] = c_new;
            if (upd_dc) st_d[1] = dc_new;
            if (upd_z)  st_d[2] = z_new;
        end
    end

    assign w_reg    = w_q;
    assign status   = st_q;
    assign f_we     = (fst_q == F_PEND);
    assign f_waddr  = fa_q;
    assign f_wdata  = fd_q;
    assign skip_out = (skip_q == SQUASH);

endmodule
